cpu_ctrl_sequencer: RTL



---
 rtl/cpu_ctrl_sequencer.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_ctrl_sequencer.sv
// +----------------------------------------------------------------------------+
// | cpu_ctrl_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM.       |
// | Optional macro CTRL_MEM_TIMEOUT_EN adds a MEM_WAIT timeout abort.           |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module cpu_ctrl_sequencer #(
  parameter int ALU_SEL_W = 4
`ifdef CTRL_MEM_TIMEOUT_EN
  , parameter int MEM_TIMEOUT = 15
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  input  logic [7:0]           instr_in,
  output logic                 instr_ready,
  output logic                 dec_en,
  output logic [7:0]           dec_opcode,
  input  logic [22:0]          dec_lines,
  input  logic [3:0]           dec_operand,
  input  logic                 zero_flag,
  input  logic                 mem_ack,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic                 alu_go,
  output logic [ALU_SEL_W-1:0] alu_sel,
  output logic                 reg_we,
  output logic                 pc_inc,
  output logic                 pc_load,
  output logic [3:0]           operand_out,
  output logic                 halted,
  output logic                 illegal,
  output logic                 timeout
);

  localparam logic [2:0] c_FETCH    = 3'd0;
  localparam logic [2:0] c_DECODE   = 3'd1;
  localparam logic [2:0] c_EXEC     = 3'd2;
  localparam logic [2:0] c_MEM_WAIT = 3'd3;
  localparam logic [2:0] c_WB       = 3'd4;
  localparam logic [2:0] c_HALT     = 3'd5;
  localparam logic [2:0] c_ILLEGAL  = 3'd6;

  localparam logic [4:0] c_L_NOP  = 5'd0;
  localparam logic [4:0] c_L_LD   = 5'd1;
  localparam logic [4:0] c_L_ST   = 5'd2;
  localparam logic [4:0] c_L_LDI  = 5'd3;
  localparam logic [4:0] c_L_MOV  = 5'd4;
  localparam logic [4:0] c_L_ALU0 = 5'd5;
  localparam logic [4:0] c_L_ALU9 = 5'd14;
  localparam logic [4:0] c_L_JMP  = 5'd15;
  localparam logic [4:0] c_L_JZ   = 5'd16;
  localparam logic [4:0] c_L_RSV0 = 5'd17;
  localparam logic [4:0] c_L_RSV1 = 5'd18;
  localparam logic [4:0] c_L_CMP0 = 5'd19;
  localparam logic [4:0] c_L_CMP2 = 5'd21;
  localparam logic [4:0] c_L_HALT = 5'd22;

  logic [2:0]           state_q, state_d;
  logic [4:0]           line_q, line_d;
  logic [7:0]           opcode_q, opcode_d;
  logic [3:0]           operand_q, operand_d;
  logic [ALU_SEL_W-1:0] alu_sel_q, alu_sel_d;
  logic                 illegal_q, illegal_d;
  logic                 alu_go_q, alu_go_d;
  logic                 pc_inc_q, pc_inc_d;
  logic                 pc_load_q, pc_load_d;
  logic                 reg_we_q, reg_we_d;
  logic                 mem_rd_q, mem_rd_d;
  logic                 mem_wr_q, mem_wr_d;
  logic [4:0]           hot_cnt;
  logic [4:0]           hot_idx;
  logic                 dec_ok;

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(MEM_TIMEOUT + 1);
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
`endif

  function automatic logic is_alu(input logic [4:0] l);
    return (l >= c_L_ALU0) && (l <= c_L_ALU9);
  endfunction

  function automatic logic is_cmp(input logic [4:0] l);
    return (l >= c_L_CMP0) && (l <= c_L_CMP2);
  endfunction

  // Exactly one non-reserved decoder line must be hot.
  always_comb begin
    hot_cnt = '0;
    hot_idx = '0;
    for (int i = 0; i < 23; i++) begin
      if (dec_lines[i]) begin
        hot_cnt = hot_cnt + 5'd1;
        hot_idx = 5'(i);
      end
    end
    dec_ok = (hot_cnt == 5'd1) && (hot_idx != c_L_RSV0) && (hot_idx != c_L_RSV1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= c_FETCH;
      line_q    <= '0;
      opcode_q  <= '0;
      operand_q <= '0;
      alu_sel_q <= '0;
      illegal_q <= 1'b0;
      alu_go_q  <= 1'b0;
      pc_inc_q  <= 1'b0;
      pc_load_q <= 1'b0;
      reg_we_q  <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
`ifdef CTRL_MEM_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      alu_sel_q <= alu_sel_d;
      illegal_q <= illegal_d;
      alu_go_q  <= alu_go_d;
      pc_inc_q  <= pc_inc_d;
      pc_load_q <= pc_load_d;
      reg_we_q  <= reg_we_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
`ifdef CTRL_MEM_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    illegal_d = illegal_q;
`ifdef CTRL_MEM_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      c_FETCH: begin
        if (instr_valid) begin
          opcode_d = instr_in;
          state_d  = c_DECODE;
        end
      end
      c_DECODE: begin
        operand_d = dec_operand;
        if (dec_ok) begin
          line_d  = hot_idx;
          state_d = c_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = c_ILLEGAL;
        end
      end
      c_EXEC: begin
`ifdef CTRL_MEM_TIMEOUT_EN
        cnt_d = '0;
`endif
        if ((line_q == c_L_LD) || (line_q == c_L_ST))
          state_d = c_MEM_WAIT;
        else if (is_alu(line_q) || (line_q == c_L_LDI) || (line_q == c_L_MOV))
          state_d = c_WB;
        else if (line_q == c_L_HALT)
          state_d = c_HALT;
        else
          state_d = c_FETCH;
      end
      c_MEM_WAIT: begin
        if (mem_ack) begin
          state_d = (line_q == c_L_LD) ? c_WB : c_FETCH;
        end
`ifdef CTRL_MEM_TIMEOUT_EN
        else if (cnt_q == c_CNT_W'(MEM_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = c_FETCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      c_WB:      state_d = c_FETCH;
      c_ILLEGAL: state_d = c_FETCH;
      c_HALT:    state_d = c_HALT;
      default:   state_d = c_FETCH;
    endcase
  end

  // Pulses are registered from the upcoming state so they are visible in the
  // state that performs them; JZ therefore samples zero_flag during DECODE.
  always_comb begin
    alu_go_d  = (state_d == c_EXEC) && (is_alu(line_d) || is_cmp(line_d));
    pc_load_d = (state_d == c_EXEC) &&
                ((line_d == c_L_JMP) || ((line_d == c_L_JZ) && zero_flag));
    pc_inc_d  = ((state_d == c_EXEC) &&
                 ((line_d == c_L_NOP) || is_cmp(line_d) || ((line_d == c_L_JZ) && !zero_flag))) ||
                (state_d == c_WB) || (state_d == c_ILLEGAL) ||
                ((state_q == c_MEM_WAIT) && (state_d == c_FETCH));
    reg_we_d  = (state_d == c_WB);
    mem_rd_d  = (state_d == c_MEM_WAIT) && (line_d == c_L_LD);
    mem_wr_d  = (state_d == c_MEM_WAIT) && (line_d == c_L_ST);
    alu_sel_d = alu_sel_q;
    if (state_d == c_EXEC) begin
      if (is_alu(line_d))
        alu_sel_d = ALU_SEL_W'(line_d - 5'd5);
      else if (is_cmp(line_d))
        alu_sel_d = ALU_SEL_W'(line_d - 5'd9);
    end
  end

  assign instr_ready = (state_q == c_FETCH);
  assign dec_en      = (state_q == c_DECODE);
  assign halted      = (state_q == c_HALT);
  assign dec_opcode  = opcode_q;
  assign operand_out = operand_q;
  assign alu_sel     = alu_sel_q;
  assign illegal     = illegal_q;
  assign alu_go      = alu_go_q;
  assign pc_inc      = pc_inc_q;
  assign pc_load     = pc_load_q;
  assign reg_we      = reg_we_q;
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;
`ifdef CTRL_MEM_TIMEOUT_EN
  assign timeout     = timeout_q;
`else
  assign timeout     = 1'b0;
`endif

endmodule

`default_nettype wire
